// File: rtl/autoref_scheduler_if.sv
// ---------------------------------------------------------------------------
// autoref_scheduler_if
// Bundles the configuration bus from the host instruction decoder and the
// per-channel refresh req/ack handshake to the command sequencer.
//
// Members:
//   set_interval, set_trfc   : config write strobes
//   cfg_ch, cfg_bcast        : write target (single channel or broadcast)
//   interval_in, trfc_in     : config write data
//   ref_ack  [NUM_CH]        : sequencer accepted refresh
//   aref_en  [NUM_CH]        : channel has a nonzero interval
//   ref_req  [NUM_CH]        : refresh request
//   ref_urgent [NUM_CH]      : pending count at its maximum
//   ref_busy [NUM_CH]        : channel inside tRFC blackout
//   pend_cnt                 : packed pending counts, ch0 in the LSBs
//   ref_ovf  [NUM_CH]        : sticky dropped-tick flag (only with AREF_OVF_EN)
//
// Modports: master = host/sequencer side, slave = scheduler.
// Optional feature macro: AREF_OVF_EN.
// ---------------------------------------------------------------------------
interface autoref_scheduler_if #(
    parameter int NUM_CH   = 8,
    parameter int CNT_W    = 28,
    parameter int MAX_PEND = 8,
    parameter int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    parameter int PEND_W   = $clog2(MAX_PEND + 1)
);
    logic                     set_interval;
    logic                     set_trfc;
    logic [CH_W-1:0]          cfg_ch;
    logic                     cfg_bcast;
    logic [CNT_W-1:0]         interval_in;
    logic [CNT_W-1:0]         trfc_in;
    logic [NUM_CH-1:0]        ref_ack;
    logic [NUM_CH-1:0]        aref_en;
    logic [NUM_CH-1:0]        ref_req;
    logic [NUM_CH-1:0]        ref_urgent;
    logic [NUM_CH-1:0]        ref_busy;
    logic [NUM_CH*PEND_W-1:0] pend_cnt;
`ifdef AREF_OVF_EN
    logic [NUM_CH-1:0]        ref_ovf;
`endif

    modport master (
`ifdef AREF_OVF_EN
        input  ref_ovf,
`endif
        output set_interval, set_trfc, cfg_ch, cfg_bcast, interval_in, trfc_in,
        output ref_ack,
        input  aref_en, ref_req, ref_urgent, ref_busy, pend_cnt
    );

    modport slave (
`ifdef AREF_OVF_EN
        output ref_ovf,
`endif
        input  set_interval, set_trfc, cfg_ch, cfg_bcast, interval_in, trfc_in,
        input  ref_ack,
        output aref_en, ref_req, ref_urgent, ref_busy, pend_cnt
    );
endinterface

// File: rtl/autoref_scheduler.sv
// ---------------------------------------------------------------------------
// autoref_scheduler
// Multi-channel auto-refresh scheduler. Each channel holds a programmable
// refresh interval and tRFC, generates a refresh tick every `interval`
// cycles, accumulates postponed refreshes up to MAX_PEND, requests a refresh
// from the command sequencer via req/ack, and blocks further requests for
// tRFC cycles after each accepted refresh. Channels are fully independent.
//
// Ports:
//   clk  : system clock
//   rstn : asynchronous active-low reset
//   bus  : autoref_scheduler_if.slave (config bus + refresh handshake)
//
// Optional feature macro: AREF_OVF_EN adds the sticky ref_ovf flags that
// record a tick arriving while a channel's pending count was saturated.
// ---------------------------------------------------------------------------
module autoref_scheduler #(
    parameter int NUM_CH   = 8,
    parameter int CNT_W    = 28,
    parameter int MAX_PEND = 8
) (
    input  logic                clk,
    input  logic                rstn,
    autoref_scheduler_if.slave  bus
);
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PEND_W = $clog2(MAX_PEND + 1);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [CNT_W-1:0]  interval_q;
        logic [CNT_W-1:0]  trfc_q;
        logic [CNT_W-1:0]  cnt_q;
        logic [CNT_W-1:0]  busy_q;
        logic [PEND_W-1:0] pend_q;
        logic              en_q;
        logic              sel;
        logic              tick;
        logic              at_max;
        logic              req;
        logic              acc;
        logic              wr_int;

        // An out-of-range cfg_ch never equals any channel index, so such a
        // write is dropped without an explicit range check.
        assign sel    = bus.cfg_bcast || (bus.cfg_ch == CH_W'(g));
        assign wr_int = bus.set_interval && sel;
        assign tick   = en_q && (cnt_q == interval_q - CNT_W'(1));
        assign at_max = (pend_q == PEND_W'(MAX_PEND));
        assign req    = (pend_q != '0) && (busy_q == '0);
        // An ack without a request is ignored entirely.
        assign acc    = bus.ref_ack[g] && req;

        // NOTE: every state register gets an async reset value and is
        // updated with non-blocking assignments so all channels sample the
        // same pre-edge state.
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                interval_q <= '0;
                trfc_q     <= '0;
                en_q       <= 1'b0;
            end else begin
                if (wr_int) begin
                    interval_q <= bus.interval_in;
                    en_q       <= |bus.interval_in;
                end
                // A new tRFC only affects the next accepted refresh.
                if (bus.set_trfc && sel) trfc_q <= bus.trfc_in;
            end
        end

        // Interval counter runs independently of busy and pending state.
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn)       cnt_q <= '0;
            else if (wr_int) cnt_q <= '0;
            else if (en_q)   cnt_q <= tick ? '0 : cnt_q + CNT_W'(1);
        end

        // Tick and accepted ack together cancel; ticks at saturation drop.
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn)
                pend_q <= '0;
            else if (wr_int && (bus.interval_in == '0))
                pend_q <= '0;
            else if (tick && !acc && !at_max)
                pend_q <= pend_q + PEND_W'(1);
            else if (acc && !tick)
                pend_q <= pend_q - PEND_W'(1);
        end

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn)                busy_q <= '0;
            else if (acc)             busy_q <= trfc_q;
            else if (busy_q != '0)    busy_q <= busy_q - CNT_W'(1);
        end

`ifdef AREF_OVF_EN
        logic ovf_q;
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn)                         ovf_q <= 1'b0;
            else if (wr_int)                   ovf_q <= 1'b0;
            else if (tick && at_max && !acc)   ovf_q <= 1'b1;
        end
        assign bus.ref_ovf[g] = ovf_q;
`else
        // Ticks arriving at saturation are discarded by the pending logic.
`endif

        assign bus.aref_en[g]                       = en_q;
        assign bus.ref_req[g]                       = req;
        assign bus.ref_urgent[g]                    = at_max;
        assign bus.ref_busy[g]                      = (busy_q != '0);
        assign bus.pend_cnt[g*PEND_W +: PEND_W]     = pend_q;
    end
endmodule

// File: tb/tb_autoref_scheduler.sv
// ---------------------------------------------------------------------------
// tb_autoref_scheduler
// Directed bench for autoref_scheduler. Main instance uses default
// parameters (8 channels, MAX_PEND=8); a second 6-channel instance exercises
// an out-of-range channel select. Inputs change 1 time unit after the rising
// edge; outputs are sampled at that same point, away from the edge.
// ---------------------------------------------------------------------------
module tb_autoref_scheduler;
    logic clk;
    logic rstn;
    int   n_cmp;
    int   n_err;

    autoref_scheduler_if #(.NUM_CH(8)) bus ();
    autoref_scheduler_if #(.NUM_CH(6)) bus2 ();

    autoref_scheduler #(.NUM_CH(8)) dut (.clk(clk), .rstn(rstn), .bus(bus.slave));
    autoref_scheduler #(.NUM_CH(6)) dut2 (.clk(clk), .rstn(rstn), .bus(bus2.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] pend_of(input int ch);
        return bus.pend_cnt[ch*4 +: 4];
    endfunction

    // One-cycle config write on the main instance.
    task automatic cfg(input logic si, input logic st, input logic bc,
                       input logic [2:0] ch, input logic [27:0] iv,
                       input logic [27:0] tv);
        bus.set_interval = si;
        bus.set_trfc     = st;
        bus.cfg_bcast    = bc;
        bus.cfg_ch       = ch;
        bus.interval_in  = iv;
        bus.trfc_in      = tv;
        step();
        bus.set_interval = 1'b0;
        bus.set_trfc     = 1'b0;
        bus.cfg_bcast    = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_cmp++;
        if ({bus.aref_en, bus.ref_req, bus.ref_urgent, bus.ref_busy, bus.pend_cnt} !== '0) begin
            n_err++;
            $display("FAIL reset_init: outputs=%h expected all zero",
                     {bus.aref_en, bus.ref_req, bus.ref_urgent, bus.ref_busy, bus.pend_cnt});
        end
        @(posedge clk); #1;
        rstn = 1'b1;
        // ch1: interval=1 (tick every cycle), trfc=5
        cfg(1'b1, 1'b1, 1'b0, 3'd1, 28'd1, 28'd5);
        step();
        n_cmp++;
        if (bus.ref_req !== 8'h02) begin
            n_err++;
            $display("FAIL reset_pre_req: ref_req=%h expected 02", bus.ref_req);
        end
        bus.ref_ack = 8'h02;
        step();
        bus.ref_ack = 8'h00;
        step();
        step();
        n_cmp++;
        if (pend_of(1) !== 4'd3 || bus.ref_busy !== 8'h02 || bus.ref_req !== 8'h00) begin
            n_err++;
            $display("FAIL reset_pre_state: pend1=%0d busy=%h req=%h expected 3 02 00",
                     pend_of(1), bus.ref_busy, bus.ref_req);
        end
        #3;
        rstn = 1'b0;
        #1;
        n_cmp++;
        if ({bus.aref_en, bus.ref_req, bus.ref_urgent, bus.ref_busy, bus.pend_cnt} !== '0) begin
            n_err++;
            $display("FAIL reset_async: outputs=%h expected all zero",
                     {bus.aref_en, bus.ref_req, bus.ref_urgent, bus.ref_busy, bus.pend_cnt});
        end
        @(posedge clk); #1;
        rstn = 1'b1;
        step();
        step();
        n_cmp++;
        if (bus.ref_req !== 8'h00 || bus.aref_en !== 8'h00) begin
            n_err++;
            $display("FAIL reset_release: req=%h aref_en=%h expected 00 00",
                     bus.ref_req, bus.aref_en);
        end
    endtask

    task automatic test_basic_period();
        logic exp_req;
        logic exp_busy;
        cfg(1'b1, 1'b1, 1'b0, 3'd2, 28'd10, 28'd4);
        for (int k = 1; k <= 30; k++) begin
            step();
            exp_req  = (k % 10 == 0);
            exp_busy = (k > 10) && (k % 10 >= 1) && (k % 10 <= 4);
            n_cmp++;
            if (bus.ref_req !== {5'b0, exp_req, 2'b0} ||
                bus.ref_busy !== {5'b0, exp_busy, 2'b0}) begin
                n_err++;
                $display("FAIL period k=%0d: req=%h busy=%h expected req=%h busy=%h",
                         k, bus.ref_req, bus.ref_busy,
                         {5'b0, exp_req, 2'b0}, {5'b0, exp_busy, 2'b0});
            end
            bus.ref_ack = exp_req ? 8'h04 : 8'h00;
        end
        bus.ref_ack = 8'h00;
        cfg(1'b1, 1'b0, 1'b0, 3'd2, 28'd0, 28'd0);
        n_cmp++;
        if (bus.aref_en !== 8'h00 || pend_of(2) !== 4'd0) begin
            n_err++;
            $display("FAIL period_disable: aref_en=%h pend2=%0d expected 00 0",
                     bus.aref_en, pend_of(2));
        end
    endtask

    task automatic test_saturate();
        int exp_p;
        cfg(1'b1, 1'b1, 1'b0, 3'd0, 28'd3, 28'd0);
        for (int k = 1; k <= 40; k++) begin
            step();
            exp_p = (k / 3 > 8) ? 8 : k / 3;
            n_cmp++;
            if (pend_of(0) !== 4'(exp_p) || bus.ref_urgent[0] !== (exp_p == 8)) begin
                n_err++;
                $display("FAIL saturate k=%0d: pend0=%0d urgent=%b expected %0d %b",
                         k, pend_of(0), bus.ref_urgent[0], exp_p, (exp_p == 8));
            end
`ifdef AREF_OVF_EN
            n_cmp++;
            if (bus.ref_ovf[0] !== (k >= 27)) begin
                n_err++;
                $display("FAIL ovf k=%0d: ref_ovf0=%b expected %b", k, bus.ref_ovf[0], (k >= 27));
            end
`endif
        end
        // Large nonzero interval keeps pend and stops new ticks for the drain.
        cfg(1'b1, 1'b0, 1'b0, 3'd0, 28'd1000, 28'd0);
        n_cmp++;
        if (pend_of(0) !== 4'd8) begin
            n_err++;
            $display("FAIL retain_pend: pend0=%0d expected 8", pend_of(0));
        end
`ifdef AREF_OVF_EN
        n_cmp++;
        if (bus.ref_ovf[0] !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_clear: ref_ovf0=%b expected 0", bus.ref_ovf[0]);
        end
`endif
        bus.ref_ack = 8'h01;
        for (int j = 1; j <= 8; j++) begin
            step();
            n_cmp++;
            if (pend_of(0) !== 4'(8 - j) || bus.ref_req[0] !== (j < 8) || bus.ref_urgent[0] !== 1'b0) begin
                n_err++;
                $display("FAIL drain j=%0d: pend0=%0d req=%b urgent=%b expected %0d %b 0",
                         j, pend_of(0), bus.ref_req[0], bus.ref_urgent[0], 8 - j, (j < 8));
            end
        end
        bus.ref_ack = 8'h00;
        cfg(1'b1, 1'b0, 1'b0, 3'd0, 28'd0, 28'd0);
    endtask

    task automatic test_simultaneous();
        cfg(1'b1, 1'b1, 1'b0, 3'd3, 28'd1, 28'd0);
        bus.ref_ack = 8'h08;
        for (int k = 1; k <= 10; k++) begin
            step();
            n_cmp++;
            if (pend_of(3) !== 4'd1 || bus.ref_req !== 8'h08) begin
                n_err++;
                $display("FAIL simul k=%0d: pend3=%0d req=%h expected 1 08",
                         k, pend_of(3), bus.ref_req);
            end
        end
        bus.ref_ack = 8'h00;
        cfg(1'b1, 1'b0, 1'b0, 3'd3, 28'd0, 28'd0);
    endtask

    task automatic test_broadcast();
        cfg(1'b1, 1'b0, 1'b1, 3'd0, 28'd20, 28'd0);
        n_cmp++;
        if (bus.aref_en !== 8'hFF) begin
            n_err++;
            $display("FAIL bcast_en: aref_en=%h expected FF", bus.aref_en);
        end
        for (int k = 1; k <= 40; k++) step();
        n_cmp++;
        if (pend_of(5) !== 4'd2) begin
            n_err++;
            $display("FAIL bcast_pend: pend5=%0d expected 2", pend_of(5));
        end
        cfg(1'b1, 1'b0, 1'b0, 3'd5, 28'd0, 28'd0);
        n_cmp++;
        if (pend_of(5) !== 4'd0 || bus.aref_en !== 8'hDF || bus.ref_req !== 8'hDF) begin
            n_err++;
            $display("FAIL disable_ch5: pend5=%0d aref_en=%h req=%h expected 0 DF DF",
                     pend_of(5), bus.aref_en, bus.ref_req);
        end
        bus.ref_ack = 8'h20;
        step();
        bus.ref_ack = 8'h00;
        n_cmp++;
        if (pend_of(5) !== 4'd0 || bus.ref_busy !== 8'h00 || bus.ref_req !== 8'hDF) begin
            n_err++;
            $display("FAIL spurious_ack: pend5=%0d busy=%h req=%h expected 0 00 DF",
                     pend_of(5), bus.ref_busy, bus.ref_req);
        end
        cfg(1'b1, 1'b0, 1'b1, 3'd0, 28'd0, 28'd0);
        n_cmp++;
        if (bus.pend_cnt !== '0 || bus.aref_en !== 8'h00) begin
            n_err++;
            $display("FAIL bcast_off: pend_cnt=%h aref_en=%h expected 0 00",
                     bus.pend_cnt, bus.aref_en);
        end
    endtask

    task automatic test_config_edge();
        logic exp_busy;
        // 6-channel instance: cfg_ch=6 is out of range and must be dropped.
        bus2.set_interval = 1'b1;
        bus2.cfg_ch       = 3'd6;
        bus2.interval_in  = 28'd5;
        step();
        n_cmp++;
        if (bus2.aref_en !== 6'h00) begin
            n_err++;
            $display("FAIL cfg_oob: aref_en=%h expected 00", bus2.aref_en);
        end
        bus2.cfg_ch = 3'd5;
        step();
        bus2.set_interval = 1'b0;
        n_cmp++;
        if (bus2.aref_en !== 6'h20) begin
            n_err++;
            $display("FAIL cfg_inrange: aref_en=%h expected 20", bus2.aref_en);
        end
        // tRFC rewrite during a running blackout.
        cfg(1'b1, 1'b1, 1'b0, 3'd4, 28'd1, 28'd3);
        step();
        bus.ref_ack = 8'h10;
        step();
        bus.ref_ack = 8'h00;
        n_cmp++;
        if (bus.ref_busy !== 8'h10) begin
            n_err++;
            $display("FAIL trfc_start: busy=%h expected 10", bus.ref_busy);
        end
        cfg(1'b0, 1'b1, 1'b0, 3'd4, 28'd0, 28'd7);
        for (int k = 3; k <= 13; k++) begin
            if (k > 3) step();
            exp_busy = (k <= 4) || (k >= 6 && k <= 12);
            n_cmp++;
            if (bus.ref_busy[4] !== exp_busy) begin
                n_err++;
                $display("FAIL trfc_rewrite k=%0d: busy4=%b expected %b", k, bus.ref_busy[4], exp_busy);
            end
            if (k == 5) begin
                n_cmp++;
                if (bus.ref_req[4] !== 1'b1) begin
                    n_err++;
                    $display("FAIL trfc_req: req4=%b expected 1", bus.ref_req[4]);
                end
                bus.ref_ack = 8'h10;
            end else begin
                bus.ref_ack = 8'h00;
            end
        end
    endtask

    initial begin
        n_cmp             = 0;
        n_err             = 0;
        rstn              = 1'b0;
        bus.set_interval  = 1'b0;
        bus.set_trfc      = 1'b0;
        bus.cfg_ch        = '0;
        bus.cfg_bcast     = 1'b0;
        bus.interval_in   = '0;
        bus.trfc_in       = '0;
        bus.ref_ack       = '0;
        bus2.set_interval = 1'b0;
        bus2.set_trfc     = 1'b0;
        bus2.cfg_ch       = '0;
        bus2.cfg_bcast    = 1'b0;
        bus2.interval_in  = '0;
        bus2.trfc_in      = '0;
        bus2.ref_ack      = '0;
        test_reset();
        test_basic_period();
        test_saturate();
        test_simultaneous();
        test_broadcast();
        test_config_edge();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
